// File: rtl/branch_predict_resolver_pkg.sv
// Shared encodings and counter helpers for the branch predictor/resolver.
// Optional statistics outputs are enabled with the BRANCH_STATS_EN macro.
package branch_predict_resolver_pkg;

   typedef enum logic [2:0] {
      BR_NONE = 3'b000,
      BR_BEQ  = 3'b001,
      BR_BNE  = 3'b010,
      BR_BLT  = 3'b011,
      BR_BGE  = 3'b100
   } br_e;

   typedef enum logic [1:0] {
      J_NONE = 2'b00,
      J_JALR = 2'b01,
      J_JAL  = 2'b10
   } jmp_e;

   typedef enum logic [1:0] {
      PCSRC_SEQ     = 2'b00,
      PCSRC_TARGET  = 2'b01,
      PCSRC_ALU     = 2'b10,
      PCSRC_RECOVER = 2'b11
   } pcsrc_e;

   // Weakly not-taken: one taken outcome flips the prediction.
   localparam logic [1:0] CTR_RESET = 2'b01;

   function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic inc);
      logic [1:0] nxt;
      nxt = cnt;
      if (inc && (cnt != 2'b11)) begin
         nxt = cnt + 2'd1;
      end else if (!inc && (cnt != 2'b00)) begin
         nxt = cnt - 2'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predict_resolver_if.sv
// Decode/Execute signal bundle between the pipeline host and the resolver.
// Optional statistics (BRANCH_STATS_EN) are plain ports on the top, not part of this bundle.
interface branch_predict_resolver_if #(
   parameter int XLEN  = 32,
   parameter int IDX_W = 6
);
   // Decode side: pcD in, prediction and table index out, all combinational.
   logic [XLEN-1:0]  pcD;
   logic             predTakenD;
   logic [IDX_W-1:0] bhtIdxD;

   // Execute side: validE qualifies every other Execute input for the current
   // cycle; there is no backpressure, so a cycle with validE = 1 is consumed
   // (resolved and, for conditional branches, trained) at the next clock edge.
   logic             validE;
   logic [2:0]       branchE;
   logic [1:0]       jumpE;
   logic             Zero;
   logic             ALU_sine;
   logic             predTakenE;
   logic [IDX_W-1:0] bhtIdxE;
   logic [1:0]       PCSrcE;
   logic             flushE;

   modport master (
      output pcD, validE, branchE, jumpE, Zero, ALU_sine, predTakenE, bhtIdxE,
      input  predTakenD, bhtIdxD, PCSrcE, flushE
   );

   modport slave (
      input  pcD, validE, branchE, jumpE, Zero, ALU_sine, predTakenE, bhtIdxE,
      output predTakenD, bhtIdxD, PCSrcE, flushE
   );

endinterface

// File: rtl/branch_predict_resolver_sat_counter2.sv
// One 2-bit saturating counter of the branch history table.
// Unaffected by the BRANCH_STATS_EN macro.
module sat_counter2
   import branch_predict_resolver_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       inc,
   output logic [1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= CTR_RESET;
      end else if (en) begin
         cnt <= sat_next(cnt, inc);
      end
   end

endmodule

// File: rtl/branch_predict_resolver.sv
// Bimodal/gshare direction predictor plus Execute-stage branch and jump resolution.
// Define BRANCH_STATS_EN to add the brCount/mispCount statistics outputs.
module branch_predict_resolver
   import branch_predict_resolver_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int BHT_ENTRIES = 64,
   parameter int HIST_W      = 0
) (
   input  logic clk,
   input  logic rst,
   branch_predict_resolver_if.slave bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0] brCount,
   output logic [31:0] mispCount
`endif
);

   localparam int IDX_W = $clog2(BHT_ENTRIES);

   logic [BHT_ENTRIES-1:0][1:0] ctr;
   logic [IDX_W-1:0]            hist_ext;
   logic [IDX_W-1:0]            idx_d;
   logic                        unused_pc_bits;

   logic   is_beq, is_bne, is_blt, is_bge;
   logic   cond_e, taken_e, train;
   pcsrc_e pcsrc;

   // ---------------- Decode-side prediction ----------------
   assign idx_d          = bus.pcD[IDX_W+1:2] ^ hist_ext;
   assign bus.bhtIdxD    = idx_d;
   // Counters are registered, so a same-cycle update is not yet visible here.
   assign bus.predTakenD = ctr[idx_d][1];
   assign unused_pc_bits = ^{bus.pcD[XLEN-1:IDX_W+2], bus.pcD[1:0]};

   // ---------------- Execute-side resolution ----------------
   always_comb begin
      is_beq  = (bus.branchE == BR_BEQ);
      is_bne  = (bus.branchE == BR_BNE);
      is_blt  = (bus.branchE == BR_BLT);
      is_bge  = (bus.branchE == BR_BGE);
      cond_e  = is_beq | is_bne | is_blt | is_bge;
      taken_e = (is_beq &  bus.Zero)     | (is_bne & ~bus.Zero) |
                (is_blt &  bus.ALU_sine) | (is_bge & ~bus.ALU_sine);

      pcsrc = PCSRC_SEQ;
      if (bus.validE) begin
         // A decoded conditional branch masks any simultaneous jump encoding.
         if (cond_e) begin
            if (taken_e && !bus.predTakenE) begin
               pcsrc = PCSRC_TARGET;
            end else if (!taken_e && bus.predTakenE) begin
               pcsrc = PCSRC_RECOVER;
            end
         end else if (bus.jumpE == J_JALR) begin
            pcsrc = PCSRC_ALU;
         end else if (bus.jumpE == J_JAL) begin
            pcsrc = PCSRC_TARGET;
         end
      end
   end

   assign bus.PCSrcE = pcsrc;
   assign bus.flushE = (pcsrc != PCSRC_SEQ);
   assign train      = bus.validE & cond_e;

   // ---------------- Counter table ----------------
   for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
      sat_counter2 u_ctr (
         .clk (clk),
         .rst (rst),
         .en  (train && (bus.bhtIdxE == IDX_W'(i))),
         .inc (taken_e),
         .cnt (ctr[i])
      );
   end

   // ---------------- Global history ----------------
   if (HIST_W > 0) begin : g_hist
      logic [HIST_W-1:0] ghr;

      always_ff @(posedge clk) begin
         if (rst) begin
            ghr <= '0;
         end else if (train) begin
            ghr <= HIST_W'({ghr, taken_e});
         end
      end

      // History occupies the most significant index bits.
      assign hist_ext = IDX_W'(ghr) << (IDX_W - HIST_W);
   end else begin : g_no_hist
      assign hist_ext = '0;
   end

`ifdef BRANCH_STATS_EN
   // ---------------- Statistics ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         brCount   <= '0;
         mispCount <= '0;
      end else if (train) begin
         brCount <= brCount + 32'd1;
         if (taken_e != bus.predTakenE) begin
            mispCount <= mispCount + 32'd1;
         end
      end
   end
`endif

endmodule
